load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the 15-bit byte-addressed dual-port RAM port protocol.
//  Accepts one load/store request at a time from the CPU pipeline and drives one RAM port.
//  Issues the RAM access sequence, including splitting accesses the RAM cannot do in one
//  access, and returns a sign-/zero-extended load result or a store completion.
// PARAMETERS
//  ADDR_W            15  byte address width; matches the RAM port address.
//  SPLIT_MISALIGNED  1   1: split misaligned accesses into legal RAM accesses; 0: reject with resp_err.
// PORTS
//  clk             in   1   system clock; all state changes on rising edge
//  rst             in   1   synchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   request accepted when req_valid & req_ready
//  req_we          in   1   1 = store, 0 = load
//  req_size        in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned    in   1   load only: 1 = zero-extend, 0 = sign-extend
//  req_addr        in   15  byte address
//  req_wdata       in   32  store data, right-justified
//  resp_valid      out  1   one-cycle completion pulse
//  resp_rdata      out  32  extended load data; 0 for stores and errors
//  resp_err        out  1   qualifies resp_valid: illegal size, or misaligned with SPLIT_MISALIGNED=0
//  mem_addr        out  15  RAM port address
//  mem_chip_select out  1   RAM port select
//  mem_op          out  2   00 read, 01 byte write, 10 half write, 11 word write (word write ignores addr[1:0])
//  mem_wdata       out  32  to RAM data_i
//  mem_rdata       in   32  from RAM data_o
//                           combinational; bits [7:0] hold the byte at mem_addr; lanes wrap within the word
//                           high-Z unless selected with op 00
// BEHAVIOUR
//  Reset:
//   - State goes to IDLE.
//   - resp_valid=0, resp_err=0, resp_rdata=0.
//   - mem_chip_select=0, mem_op=00, mem_addr=0, mem_wdata=0.
//   - req_ready=0 while rst=1.
//  Reset mid-operation:
//   - Abort the sequence and issue no response.
//   - RAM bytes already written stay written; there is no rollback.
//  States: IDLE, ACC0, ACC1, BYTEWR, RESP.
//   - req_ready = (state==IDLE) & ~rst. The request is captured on accept.
//   - mem_chip_select=1 only in ACC0, ACC1 and BYTEWR.
//  Legal single access (byte; half at offset 0/1/2; word at offset 0):
//   - Sequence: IDLE -> ACC0 -> RESP -> IDLE.
//   - resp_valid is asserted 2 cycles after the accept edge.
//   - Store: op 01/10/11 at req_addr. The RAM write lands on the ACC0->RESP edge.
//   - Load: op 00. mem_rdata is sampled at the end of ACC0.
//  Misaligned load (half at offset 3; word at offset 1-3):
//   - Sequence: ACC0 reads req_addr, then ACC1 reads {req_addr[14:2]+1, 2'b00}.
//   - Let n0 = 4 - req_addr[1:0]. Result = low n0 bytes of the ACC0 data, then the low bytes of the ACC1 data.
//   - Latency is 3 cycles.
//  Misaligned store:
//   - BYTEWR issues 2 (half) or 4 (word) op-01 writes, one per cycle.
//   - Write k goes to address req_addr+k with wdata byte k in mem_wdata[7:0].
//   - Latency is 1+N cycles.
//  Address arithmetic: modulo 2^ADDR_W. Word index 0x1FFF+1 wraps to 0; byte 0x7FFF+1 wraps to 0.
//  Error path (req_size=11, or misaligned with SPLIT_MISALIGNED=0):
//   - Sequence: IDLE -> RESP with no RAM access.
//   - resp_err=1; latency is 1 cycle.
//  Load extension:
//   - Byte/half: sign-extend from bit 7/15 unless req_unsigned.
//   - Word: passed through unchanged.
//  Back-to-back requests: the next accept is possible in the cycle after RESP.
//   req_valid held high during a busy cycle is ignored.
//  mem_wdata for legal stores = req_wdata unchanged (the RAM selects lanes from addr[1:0]).
// STRUCTURE
//  Package mem_pkg holds:
//   - SIZE_B/H/W encodings;
//   - MEM_OP_READ/BYTE/HALF/WORD constants;
//   - the lsu_state_t enum;
//   - function is_misaligned(size, off).
//  Sub-module lsu_load_align (combinational):
//   - merges the ACC0/ACC1 data by n0;
//   - performs the sign/zero extension.
//  FSM and sequencing stay in the top module.
// TESTING
//  - Aligned LW @0x0010, RAM word 0xDEADBEEF.
//    -> one op-00 access; resp_rdata=0xDEADBEEF 2 cycles after accept.
//  - LB @0x0013 (byte 0x80), signed then unsigned.
//    -> 0xFFFFFF80, then 0x00000080.
//  - LW @0x0006 with bytes 04..0B = 11 22 33 44 55 66 77 88.
//    -> reads @0x0006 then @0x0008; resp_rdata=0x66554433; latency 3.
//  - SW 0xA1B2C3D4 @0x7FFF.
//    -> byte writes to 0x7FFF, 0x0000, 0x0001, 0x0002 (D4, C3, B2, A1); latency 5.
//  - SH @0x0003 with SPLIT_MISALIGNED=0, and req_size=11 @0x0000.
//    -> resp_err=1, no mem_chip_select, latency 1.
//  - rst asserted during the 2nd byte of a split SW.
//    -> next edge: IDLE, no response; byte 0 written, bytes 2-3 unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit and its helpers.
//   - request size encodings (SIZE_*)
//   - RAM port operation codes (MEM_OP_*)
//   - load/store sequencer state type (lsu_state_t)
//   - helpers: misalignment test, size-to-write-op mapping
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;  // illegal

  localparam logic [1:0] MEM_OP_READ = 2'b00;
  localparam logic [1:0] MEM_OP_BYTE = 2'b01;
  localparam logic [1:0] MEM_OP_HALF = 2'b10;
  localparam logic [1:0] MEM_OP_WORD = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StByteWr,
    StResp
  } lsu_state_t;

  // The RAM handles a half at offsets 0..2 and a word only at offset 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_H:  mis = (off == 2'd3);
      SIZE_W:  mis = (off != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] size_to_op(input logic [1:0] size);
    logic [1:0] op;
    case (size)
      SIZE_B:  op = MEM_OP_BYTE;
      SIZE_H:  op = MEM_OP_HALF;
      SIZE_W:  op = MEM_OP_WORD;
      default: op = MEM_OP_READ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data formatter.
//   lo_data      in  32  first access data (byte at the request address in [7:0])
//   hi_data      in  32  second access data (byte at the next word base in [7:0])
//   split        in  1   1: merge lo/hi; 0: lo_data is already right-justified
//   n0           in  3   bytes taken from lo_data when split (1..3)
//   size         in  2   load size
//   is_unsigned  in  1   zero-extend instead of sign-extend
//   rdata        out 32  extended result
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] lo_data,
  input  logic [31:0] hi_data,
  input  logic        split,
  input  logic [2:0]  n0,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [31:0] merged;
  logic        sign_b;
  logic        sign_h;

  always_comb begin
    merged = lo_data;
    if (split) begin
      case (n0)
        3'd1:    merged = {hi_data[23:0], lo_data[7:0]};
        3'd2:    merged = {hi_data[15:0], lo_data[15:0]};
        3'd3:    merged = {hi_data[7:0], lo_data[23:0]};
        default: merged = lo_data;
      endcase
    end
  end

  assign sign_b = ~is_unsigned & merged[7];
  assign sign_h = ~is_unsigned & merged[15];

  always_comb begin
    case (size)
      SIZE_B:  rdata = {{24{sign_b}}, merged[7:0]};
      SIZE_H:  rdata = {{16{sign_h}}, merged[15:0]};
      default: rdata = merged;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one CPU load/store at a time and sequences it onto a single
// byte-addressed RAM port, splitting misaligned accesses when enabled.
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; request captured on accept
//   req_we/size/unsigned/addr/wdata  request fields
//   resp_valid/resp_rdata/resp_err   one-cycle completion pulse with load data or error
//   mem_addr/mem_chip_select/mem_op/mem_wdata  RAM port drive (all registered)
//   mem_rdata                   RAM read data, valid while selected with a read op
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W           = 15,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_chip_select,
  output logic [1:0]        mem_op,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       data0_q, data0_d;

  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_cs_q, mem_cs_d;
  logic [1:0]        mem_op_q, mem_op_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              req_mis;
  logic              cur_mis;
  logic [1:0]        cnt_next;
  logic [1:0]        last_byte;
  logic [ADDR_W-3:0] next_word;
  logic [31:0]       align_rdata;

  assign req_ready = (state_q == StIdle) & ~rst;

  assign req_mis   = is_misaligned(req_size, req_addr[1:0]);
  assign cur_mis   = is_misaligned(size_q, addr_q[1:0]);
  assign cnt_next  = cnt_q + 2'd1;
  assign last_byte = (size_q == SIZE_H) ? 2'd1 : 2'd3;
  // Word index increment wraps naturally at the top of the address space.
  assign next_word = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);

  // In ACC1 the first word is the one captured at the end of ACC0.
  lsu_load_align u_align (
    .lo_data     ((state_q == StAcc1) ? data0_q : mem_rdata),
    .hi_data     (mem_rdata),
    .split       (state_q == StAcc1),
    .n0          (3'd4 - {1'b0, addr_q[1:0]}),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (align_rdata)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    data0_d      = data0_q;
    // Outputs are pulses/strobes: idle values unless a transition sets them.
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_addr_d   = '0;
    mem_cs_d     = 1'b0;
    mem_op_d     = MEM_OP_READ;
    mem_wdata_d  = '0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 2'd0;
          if ((req_size == SIZE_X) || (req_mis && !SPLIT_MISALIGNED)) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_mis && req_we) begin
            state_d     = StByteWr;
            mem_cs_d    = 1'b1;
            mem_op_d    = MEM_OP_BYTE;
            mem_addr_d  = req_addr;
            mem_wdata_d = {24'h0, req_wdata[7:0]};
          end else begin
            state_d     = StAcc0;
            mem_cs_d    = 1'b1;
            mem_op_d    = req_we ? size_to_op(req_size) : MEM_OP_READ;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_we ? req_wdata : 32'h0;
          end
        end
      end

      StAcc0: begin
        if (!we_q && cur_mis) begin
          state_d    = StAcc1;
          data0_d    = mem_rdata;
          mem_cs_d   = 1'b1;
          mem_op_d   = MEM_OP_READ;
          mem_addr_d = {next_word, 2'b00};
        end else begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'h0 : align_rdata;
        end
      end

      StAcc1: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_rdata_d = align_rdata;
      end

      StByteWr: begin
        if (cnt_q == last_byte) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d       = cnt_next;
          mem_cs_d    = 1'b1;
          mem_op_d    = MEM_OP_BYTE;
          mem_addr_d  = addr_q + ADDR_W'(cnt_next);
          mem_wdata_d = {24'h0, wdata_q[{cnt_next, 3'b000} +: 8]};
        end
      end

      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= SIZE_B;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 2'd0;
      data0_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_cs_q     <= 1'b0;
      mem_op_q     <= MEM_OP_READ;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      data0_q      <= data0_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_cs_q     <= mem_cs_d;
      mem_op_q     <= mem_op_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;
  assign mem_addr        = mem_addr_q;
  assign mem_chip_select = mem_cs_q;
  assign mem_op          = mem_op_q;
  assign mem_wdata       = mem_wdata_q;

endmodule
